// File: rtl/pixel_streamer_pkg.sv
// Shared definitions for the pixel streamer: FSM encoding and image/result geometry helpers.
package pixel_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    function automatic int calc_npix(input int ix, input int iy);
        return ix * iy;
    endfunction

    // Valid-padding convolution: one result per full kernel placement.
    function automatic int calc_nres(input int ix, input int iy, input int kx, input int ky);
        return (ix - kx + 1) * (iy - ky + 1);
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_streamer_mem.sv
// Image store for the pixel streamer: single write port, registered read port.
module pixel_mem
    import pixel_streamer_pkg::*;
#(
    parameter int I_F_BW = 8,
    parameter int NPIX   = 784,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [I_F_BW-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [I_F_BW-1:0] rd_data_o
);
    localparam int            MW     = (clog2(NPIX) < 1) ? 1 : clog2(NPIX);
    localparam logic [AW:0]   NPIX_W = (AW+1)'(NPIX);

    logic [I_F_BW-1:0] mem_q [NPIX];
    logic [I_F_BW-1:0] rd_data_p1_q;
    logic [MW-1:0]     wr_idx;
    logic [MW-1:0]     rd_idx;
    logic              wr_ok;

    assign wr_idx = wr_addr_i[MW-1:0];
    assign rd_idx = rd_addr_i[MW-1:0];
    assign wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < NPIX_W);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // Read stage p0 -> p1: data register only moves on a read, so it holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_p1_q <= '0;
        end else if (rd_en_i) begin
            rd_data_p1_q <= mem_q[rd_idx];
        end
    end

    assign rd_data_o = rd_data_p1_q;

endmodule

// File: rtl/pixel_streamer.sv
// Streams a stored image in raster order to the convolution core, then counts the
// returned results and reports frame completion or a result timeout.
module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int I_F_BW = 8,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int AW     = 10,
    parameter int TO_BW  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [I_F_BW-1:0] i_wr_data,
    input  logic              i_start,
    input  logic              i_hold,
    input  logic              i_res_valid,
    output logic              o_ot_valid,
    output logic [I_F_BW-1:0] o_ot_pixel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [AW-1:0]     o_res_cnt
);
    localparam int               NPIX      = calc_npix(IX, IY);
    localparam int               N_RES     = calc_nres(IX, IY, KX, KY);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW-1:0]    RES_MAX   = AW'(N_RES);
    localparam logic [TO_BW-1:0] TO_LAST   = TO_BW'((1 << TO_BW) - 2);

    state_t            state_q, state_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [AW-1:0]     res_cnt_q, res_cnt_d;
    logic [TO_BW-1:0]  to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic              vld_p1_q;
    logic              rd_en;
    logic              mem_wr_en;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (v == RES_MAX) ? v : v + 1'b1;
    endfunction

    assign mem_wr_en = i_wr_en && (state_q != ST_STREAM);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        res_cnt_d = res_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        rd_en     = 1'b0;

        if (i_res_valid && ((state_q == ST_STREAM) || (state_q == ST_WAIT_RES))) begin
            res_cnt_d = sat_inc(res_cnt_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_STREAM;
                    rd_addr_d = '0;
                    res_cnt_d = '0;
                    to_cnt_d  = '0;
                    err_d     = 1'b0;
                end
            end
            ST_STREAM: begin
                if (!i_hold) begin
                    rd_en     = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d  = ST_WAIT_RES;
                        to_cnt_d = '0;
                    end
                end
            end
            ST_WAIT_RES: begin
                // Completion wins over a timeout that expires in the same cycle.
                if (res_cnt_q == RES_MAX) begin
                    state_d = ST_DONE;
                end else if (i_res_valid) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control stage p0 -> p1: pixel valid is registered alongside the memory read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            res_cnt_q <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
            vld_p1_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            res_cnt_q <= res_cnt_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
            vld_p1_q  <= rd_en;
        end
    end

    pixel_mem #(
        .I_F_BW (I_F_BW),
        .NPIX   (NPIX),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (i_wr_addr),
        .wr_data_i (i_wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (o_ot_pixel)
    );

    assign o_ot_valid = vld_p1_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_err      = err_q;
    assign o_res_cnt  = res_cnt_q;

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Transmit-side partner of the convolution core: holds one IX×IY single-channel image and streams it out in raster order as a valid-qualified pixel stream, one pixel per cycle, matching the core's i_in_valid / i_in_fmap input.
- Counts the convolution results that come back on the core's output-valid line and reports frame completion, or a timeout error.
- Sits between the image loader (UART or host write port) and the convolution core.

Parameters:
- I_F_BW, 8, pixel width in bits
- IX, 28, image width in pixels
- IY, 28, image height in pixels
- KX, 5, kernel width; used only to compute N_RES
- KY, 5, kernel height; used only to compute N_RES
- AW, 10, address width; must satisfy 2^AW ≥ IX*IY
- TO_BW, 12, timeout counter width; the timeout is 2^TO_BW−1 cycles

Ports:
- clk, input, 1, clock
- reset_n, input, 1, asynchronous active-low reset
- i_wr_en, input, 1, image write strobe
- i_wr_addr, input, AW, raster address of the pixel to write (y*IX+x)
- i_wr_data, input, I_F_BW, pixel value to write
- i_start, input, 1, start one frame; level-sampled
- i_hold, input, 1, throttle: while high, no new pixel is issued
- i_res_valid, input, 1, result-valid returned from the convolution core
- o_ot_valid, output, 1, pixel valid to the core
- o_ot_pixel, output, I_F_BW, pixel data to the core
- o_busy, output, 1, high in every state except IDLE
- o_done, output, 1, one-cycle pulse when the frame completes
- o_err, output, 1, sticky timeout flag; cleared by the next accepted i_start
- o_res_cnt, output, AW, number of results received in the current frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Constants: NPIX = IX*IY. N_RES = (IX−KX+1)*(IY−KY+1); 576 at the defaults.
- Reset values: all outputs are 0, state is IDLE, all counters are 0. Image memory contents are not reset.
- Memory: NPIX×I_F_BW array.
  - Synchronous write in any state other than STREAM.
  - Writes during STREAM are dropped.
  - i_wr_addr ≥ NPIX is ignored.
  - Read is registered, 1-cycle latency.
- States: IDLE, STREAM, WAIT_RES, DONE.
- IDLE:
  - i_start=1 → STREAM; rd_addr←0; o_res_cnt←0; o_err←0.
  - A write and a start in the same cycle are both accepted. The written pixel is visible to the stream.
- STREAM:
  - Each cycle with i_hold=0: read mem[rd_addr], rd_addr++.
  - o_ot_valid=1 in the following cycle, with o_ot_pixel = that data.
  - Each cycle with i_hold=1: no read issued; o_ot_valid=0 in the following cycle.
  - o_ot_pixel holds its last value whenever o_ot_valid=0.
  - Issuing address NPIX−1 → WAIT_RES; the last pixel appears one cycle later.
  - With i_hold=0 throughout, exactly NPIX contiguous valid cycles are produced. The first is in the cycle after the second clock edge after i_start is sampled.
- Result counting:
  - Active in STREAM and WAIT_RES. Each i_res_valid=1 increments o_res_cnt, saturating at N_RES.
  - i_res_valid in IDLE or DONE is ignored.
- WAIT_RES:
  - o_res_cnt == N_RES → DONE. This check also covers the count being reached in the cycle of entry.
  - Timeout counter starts at 0 on entry and increments every cycle with no i_res_valid; it resets to 0 on each i_res_valid.
  - Counter reaching 2^TO_BW−1 → o_err←1 and go to DONE.
- DONE:
  - o_done=1 for exactly one cycle, then → IDLE.
  - o_res_cnt holds its value until the next start.
- i_start while o_busy=1 is ignored.
- Reset asserted mid-frame:
  - Immediately: o_ot_valid=0, state IDLE.
  - No o_done pulse. The partial frame is abandoned.
  - The downstream core is reset by the same reset_n.
- Arithmetic: all counters are unsigned; no value wraps within a frame.

Decomposition:
- Shared package holds: state encoding (IDLE/STREAM/WAIT_RES/DONE), NPIX and N_RES derivation functions, clog2 helper.
- One sub-module, pixel_mem: single-port write, registered read, NPIX×I_F_BW.
- The FSM, counters and timeout logic live in pixel_streamer.

Test Plan:
- Load mem[a]=a mod 256 for all 784 pixels; pulse i_start; i_hold=0 → 784 contiguous o_ot_valid cycles with pixels 0,1,…,255,0,…; first valid 2 edges after start; o_busy=1 from the cycle after start.
- Same frame with the core instantiated downstream → o_res_cnt reaches 576; one-cycle o_done; o_err=0; then IDLE.
- i_hold pattern 1-of-3 cycles high during STREAM → still 784 valid pixels, in order, no duplicates; valid gaps align with hold cycles delayed by 1.
- i_res_valid never asserted after the stream ends → o_err=1 and o_done pulse exactly 4095 cycles after entry into WAIT_RES; next i_start clears o_err.
- Write to mem[5]=0xAA during STREAM, plus i_start repeated mid-frame → write dropped (the next frame reads the old value); second start ignored, no restart.
- reset_n low at pixel 300 → o_ot_valid=0 asynchronously, no o_done; after release, a new start streams the full 784 pixels from address 0.
